// File: rtl/attempt_counter_display.sv
// attempt_counter_display: failed-attempt counter with BCD count, lockout and
// multi-digit active-low seven-segment output.
//   clk           - system clock, rising edge
//   rst           - asynchronous active-high reset
//   attempt_fail  - one-cycle pulse per failed passcode entry
//   attempt_ok    - one-cycle pulse per correct entry (clears count)
//   clear         - supervisor clear (exits lockout, zeroes count)
//   attempt_count - BCD count, digit 0 in [3:0]
//   counter_out   - segments {g,f,e,d,c,b,a} per digit, active low, digit 0 in [6:0]
//   locked        - high while locked out
module attempt_counter_display #(
   parameter int unsigned NUM_DIGITS    = 2,
   parameter int unsigned MAX_ATTEMPTS  = 5,
   parameter int unsigned BLINK_DIV     = 25000000,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    attempt_fail,
   input  logic                    attempt_ok,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] attempt_count,
   output logic [7*NUM_DIGITS-1:0] counter_out,
   output logic                    locked
);

   localparam int unsigned CW = 4 * NUM_DIGITS;
   localparam int unsigned SW = 7 * NUM_DIGITS;
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Binary to packed BCD, used for the lockout threshold constant.
   function automatic logic [CW-1:0] to_bcd(input int unsigned v);
      int unsigned r;
      r      = v;
      to_bcd = '0;
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
         to_bcd[4*d +: 4] = 4'(r % 10);
         r = r / 10;
      end
   endfunction

   localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_ATTEMPTS);

   // BCD increment with per-digit 9 -> 0 carry.
   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic carry;
      carry   = 1'b1;
      bcd_inc = v;
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
         if (carry) begin
            if (v[4*d +: 4] == 4'd9) begin
               bcd_inc[4*d +: 4] = 4'd0;
            end else begin
               bcd_inc[4*d +: 4] = v[4*d +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   endfunction

   // Single digit to active-low segments.
   function automatic logic [6:0] seg_digit(input logic [3:0] v);
      case (v)
         4'd0:    seg_digit = 7'b1000000;
         4'd1:    seg_digit = 7'b1111001;
         4'd2:    seg_digit = 7'b0100100;
         4'd3:    seg_digit = 7'b0110000;
         4'd4:    seg_digit = 7'b0011001;
         4'd5:    seg_digit = 7'b0010010;
         4'd6:    seg_digit = 7'b0000010;
         4'd7:    seg_digit = 7'b1111000;
         4'd8:    seg_digit = 7'b0000000;
         4'd9:    seg_digit = 7'b0010000;
         default: seg_digit = SEG_BLANK;
      endcase
   endfunction

   // Full display frame; scans from the top digit so leading zeros can be blanked.
   function automatic logic [SW-1:0] encode(input logic [CW-1:0] cnt,
                                            input logic lock,
                                            input logic phase_on);
      logic leading;
      leading = 1'b1;
      encode  = '0;
      for (int d = int'(NUM_DIGITS) - 1; d >= 0; d--) begin
         if (lock) begin
            encode[7*d +: 7] = phase_on ? SEG_F : SEG_BLANK;
         end else if ((BLANK_LEADING != 0) && leading && (d != 0) &&
                      (cnt[4*d +: 4] == 4'd0)) begin
            encode[7*d +: 7] = SEG_BLANK;
         end else begin
            leading          = 1'b0;
            encode[7*d +: 7] = seg_digit(cnt[4*d +: 4]);
         end
      end
   endfunction

   typedef enum logic {
      S_COUNTING = 1'b0,
      S_LOCKED   = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  count_nxt;
   logic [CW-1:0]  count_inc;
   logic [BW-1:0]  blink_cnt;
   logic [BW-1:0]  blink_cnt_nxt;
   logic           phase_on;
   logic           phase_nxt;

   // Next-state values; the display frame is derived from these so that all
   // outputs change together on the same edge.
   always_comb begin
      state_nxt     = state;
      count_nxt     = attempt_count;
      blink_cnt_nxt = blink_cnt;
      phase_nxt     = phase_on;
      count_inc     = bcd_inc(attempt_count);
      if (clear) begin
         state_nxt     = S_COUNTING;
         count_nxt     = '0;
         blink_cnt_nxt = '0;
         phase_nxt     = 1'b1;
      end else begin
         case (state)
            S_COUNTING: begin
               if (attempt_fail) begin
                  count_nxt = count_inc;
                  if (count_inc == MAX_BCD) begin
                     state_nxt     = S_LOCKED;
                     blink_cnt_nxt = '0;
                     phase_nxt     = 1'b1;
                  end
               end else if (attempt_ok) begin
                  count_nxt = '0;
               end
            end
            S_LOCKED: begin
               if (blink_cnt == BLINK_LAST) begin
                  blink_cnt_nxt = '0;
                  phase_nxt     = ~phase_on;
               end else begin
                  blink_cnt_nxt = blink_cnt + BW'(1);
               end
            end
            default: state_nxt = S_COUNTING;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_COUNTING;
         attempt_count <= '0;
         blink_cnt     <= '0;
         phase_on      <= 1'b1;
         locked        <= 1'b0;
         counter_out   <= encode('0, 1'b0, 1'b1);
      end else begin
         state         <= state_nxt;
         attempt_count <= count_nxt;
         blink_cnt     <= blink_cnt_nxt;
         phase_on      <= phase_nxt;
         locked        <= (state_nxt == S_LOCKED);
         counter_out   <= encode(count_nxt, state_nxt == S_LOCKED, phase_nxt);
      end
   end

endmodule
